// File: rtl/risc16_regfile_sb_pkg.sv
// risc16_regfile_sb_pkg
// Shared definitions for the RISC16 register file with scoreboard:
// default parameter values and the index of the hard-wired zero register.
// No ports (package).

package risc16_regfile_sb_pkg;

    localparam int DEF_WORD_LENGTH  = 16;
    localparam int DEF_REG_ADDR_LEN = 3;
    localparam int DEF_REG_NUM      = 8;
    localparam int DEF_PEND_W       = 2;
    localparam int DEF_BYPASS       = 1;

    // Register 0 always reads zero and never holds data or reservations.
    localparam int ZERO_REG = 0;

endpackage : risc16_regfile_sb_pkg

// File: rtl/risc16_regfile_sb_if.sv
// risc16_regfile_sb_if
// Bus bundle between the pipeline (master) and the register file (slave).
//   addr1/src1/busy1 : read port 1 address, data, outstanding-write flag
//   addr2/src2/busy2 : read port 2 address, data, outstanding-write flag
//   addrT/trgt/wen   : write address, write data, write enable
//   addrR/resv       : reservation address and request
//   ovf              : one-cycle pulse, reservation dropped on saturated counter

interface risc16_regfile_sb_if
    import risc16_regfile_sb_pkg::*;
#(
    parameter int WORD_LENGTH  = DEF_WORD_LENGTH,
    parameter int REG_ADDR_LEN = DEF_REG_ADDR_LEN
) ();

    logic [REG_ADDR_LEN-1:0] addr1;
    logic [WORD_LENGTH-1:0]  src1;
    logic                    busy1;

    logic [REG_ADDR_LEN-1:0] addr2;
    logic [WORD_LENGTH-1:0]  src2;
    logic                    busy2;

    logic [REG_ADDR_LEN-1:0] addrT;
    logic [WORD_LENGTH-1:0]  trgt;
    logic                    wen;

    logic [REG_ADDR_LEN-1:0] addrR;
    logic                    resv;

    logic                    ovf;

    modport master (
        output addr1, addr2, addrT, trgt, wen, addrR, resv,
        input  src1, src2, busy1, busy2, ovf
    );

    modport slave (
        input  addr1, addr2, addrT, trgt, wen, addrR, resv,
        output src1, src2, busy1, busy2, ovf
    );

endinterface : risc16_regfile_sb_if

// File: rtl/risc16_regfile_sb_pend_counter.sv
// risc16_pend_counter
// Saturating pending-write counter for one register.
//   clk : rising-edge clock
//   inc : reservation of this register
//   dec : write to this register
//   clr : synchronous clear (highest priority)
//   cnt : current number of outstanding writes
//   sat : cnt is at its maximum value

module risc16_pend_counter
    import risc16_regfile_sb_pkg::*;
#(
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] cnt,
    output logic              sat
);

    assign sat = (cnt == {PEND_W{1'b1}});

    // Simultaneous inc and dec cancel. Increment stops at saturation and
    // decrement stops at zero, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && !sat) begin
            cnt <= cnt + PEND_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - PEND_W'(1);
        end
    end

endmodule : risc16_pend_counter

// File: rtl/risc16_regfile_sb.sv
// risc16_regfile_sb
// Two-read, one-write register file with a per-register scoreboard of
// outstanding writes and optional write-to-read forwarding.
//   clk : rising-edge clock
//   rst : synchronous active-high reset of data, counters and ovf
//   bus : slave side of risc16_regfile_sb_if (read ports, write port,
//         reservation port, ovf pulse)

module risc16_regfile_sb
    import risc16_regfile_sb_pkg::*;
#(
    parameter int WORD_LENGTH  = DEF_WORD_LENGTH,
    parameter int REG_ADDR_LEN = DEF_REG_ADDR_LEN,
    parameter int REG_NUM      = DEF_REG_NUM,
    parameter int PEND_W       = DEF_PEND_W,
    parameter int BYPASS       = DEF_BYPASS
) (
    input  logic                clk,
    input  logic                rst,
    risc16_regfile_sb_if.slave  bus
);

    localparam int FIRST_REG = ZERO_REG + 1;

    logic [WORD_LENGTH-1:0] regs    [FIRST_REG:REG_NUM-1];
    logic [PEND_W-1:0]      cnt     [FIRST_REG:REG_NUM-1];
    logic                   sat     [FIRST_REG:REG_NUM-1];

    logic [WORD_LENGTH-1:0] src1_val;
    logic [WORD_LENGTH-1:0] src2_val;
    logic                   busy1_val;
    logic                   busy2_val;
    logic                   ovf_next;
    logic                   ovf_q;
    logic                   hit1;
    logic                   hit2;

    // Data storage. Writes are decoded by scanning the valid nonzero
    // indices, so register 0 and out-of-range addresses fall through.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = FIRST_REG; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wen) begin
            for (int i = FIRST_REG; i < REG_NUM; i++) begin
                if (bus.addrT == REG_ADDR_LEN'(i)) begin
                    regs[i] <= bus.trgt;
                end
            end
        end
    end

    // One pending counter per nonzero register.
    for (genvar g = FIRST_REG; g < REG_NUM; g++) begin : g_pend
        risc16_pend_counter #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .clk (clk),
            .inc (bus.resv && (bus.addrR == REG_ADDR_LEN'(g))),
            .dec (bus.wen  && (bus.addrT == REG_ADDR_LEN'(g))),
            .clr (rst),
            .cnt (cnt[g]),
            .sat (sat[g])
        );
    end

    // A write matching a read address is forwarded with bypass enabled.
    // The same write retires one pending count, so busy only reports
    // writes still outstanding beyond the one landing this cycle.
    always_comb begin
        hit1      = (BYPASS != 0) && bus.wen && (bus.addrT == bus.addr1);
        hit2      = (BYPASS != 0) && bus.wen && (bus.addrT == bus.addr2);
        src1_val  = '0;
        src2_val  = '0;
        busy1_val = 1'b0;
        busy2_val = 1'b0;
        for (int i = FIRST_REG; i < REG_NUM; i++) begin
            if (bus.addr1 == REG_ADDR_LEN'(i)) begin
                src1_val  = hit1 ? bus.trgt : regs[i];
                busy1_val = cnt[i] > PEND_W'(hit1);
            end
            if (bus.addr2 == REG_ADDR_LEN'(i)) begin
                src2_val  = hit2 ? bus.trgt : regs[i];
                busy2_val = cnt[i] > PEND_W'(hit2);
            end
        end
    end

    // A reservation is lost only when its counter is saturated and no
    // write to the same register cancels it in the same cycle.
    always_comb begin
        ovf_next = 1'b0;
        for (int i = FIRST_REG; i < REG_NUM; i++) begin
            if (bus.resv && (bus.addrR == REG_ADDR_LEN'(i)) && sat[i] &&
                !(bus.wen && (bus.addrT == REG_ADDR_LEN'(i)))) begin
                ovf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_next;
        end
    end

    assign bus.src1  = src1_val;
    assign bus.src2  = src2_val;
    assign bus.busy1 = busy1_val;
    assign bus.busy2 = busy2_val;
    assign bus.ovf   = ovf_q;

endmodule : risc16_regfile_sb

// File: tb/tb_risc16_regfile_sb.sv
// tb_risc16_regfile_sb
// Directed bench for risc16_regfile_sb with default parameters.
// Each step drives inputs, pushes the expected outputs (from a small
// behavioural model) onto a scoreboard queue, then pops and compares.

module tb_risc16_regfile_sb;

    typedef struct {
        string       tag;
        logic [15:0] src1;
        logic [15:0] src2;
        logic        busy1;
        logic        busy2;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;

    risc16_regfile_sb_if #(.WORD_LENGTH(16), .REG_ADDR_LEN(3)) bus ();

    risc16_regfile_sb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          assertions = 0;
    int          failures   = 0;

    logic [15:0] mregs [8];
    int          mcnt  [8];
    logic        movf;

    function automatic logic [15:0] modelRead(input logic [2:0] a,
                                              input logic w,
                                              input logic [2:0] aT,
                                              input logic [15:0] t);
        if (a == 3'd0) return 16'h0000;
        if (w && aT == a) return t;
        return mregs[a];
    endfunction

    function automatic logic modelBusy(input logic [2:0] a,
                                       input logic w,
                                       input logic [2:0] aT);
        int h;
        if (a == 3'd0) return 1'b0;
        h = (w && aT == a) ? 1 : 0;
        return mcnt[a] > h;
    endfunction

    task automatic modelEdge(input logic [2:0] aT, input logic [15:0] t,
                             input logic w, input logic [2:0] aR,
                             input logic rv, input logic r);
        logic inc;
        logic dec;
        if (r) begin
            for (int i = 0; i < 8; i++) begin
                mregs[i] = 16'h0000;
                mcnt[i]  = 0;
            end
            movf = 1'b0;
            return;
        end
        movf = 1'b0;
        inc  = rv && (aR != 3'd0);
        dec  = w && (aT != 3'd0);
        if (!(inc && dec && aR == aT)) begin
            if (inc) begin
                if (mcnt[aR] == 3) movf = 1'b1;
                else mcnt[aR] = mcnt[aR] + 1;
            end
            if (dec && mcnt[aT] > 0) mcnt[aT] = mcnt[aT] - 1;
        end
        if (dec) mregs[aT] = t;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL scoreboard_empty observed=0 entries expected=1");
            return;
        end
        e = sb.pop_front();
        assertions++;
        assert (bus.src1 === e.src1) else begin
            failures++;
            $error("[TB] FAIL %s.src1 observed=%h expected=%h", e.tag, bus.src1, e.src1);
        end
        assertions++;
        assert (bus.src2 === e.src2) else begin
            failures++;
            $error("[TB] FAIL %s.src2 observed=%h expected=%h", e.tag, bus.src2, e.src2);
        end
        assertions++;
        assert (bus.busy1 === e.busy1) else begin
            failures++;
            $error("[TB] FAIL %s.busy1 observed=%b expected=%b", e.tag, bus.busy1, e.busy1);
        end
        assertions++;
        assert (bus.busy2 === e.busy2) else begin
            failures++;
            $error("[TB] FAIL %s.busy2 observed=%b expected=%b", e.tag, bus.busy2, e.busy2);
        end
        assertions++;
        assert (bus.ovf === e.ovf) else begin
            failures++;
            $error("[TB] FAIL %s.ovf observed=%b expected=%b", e.tag, bus.ovf, e.ovf);
        end
    endtask

    task automatic applyStimulus(input string tag,
                                 input logic [2:0] a1, input logic [2:0] a2,
                                 input logic [2:0] aT, input logic [15:0] t,
                                 input logic w, input logic [2:0] aR,
                                 input logic rv, input logic r);
        exp_t e;
        @(negedge clk);
        bus.addr1 = a1;
        bus.addr2 = a2;
        bus.addrT = aT;
        bus.trgt  = t;
        bus.wen   = w;
        bus.addrR = aR;
        bus.resv  = rv;
        rst       = r;
        e.tag   = tag;
        e.src1  = modelRead(a1, w, aT, t);
        e.src2  = modelRead(a2, w, aT, t);
        e.busy1 = modelBusy(a1, w, aT);
        e.busy2 = modelBusy(a2, w, aT);
        e.ovf   = movf;
        sb.push_back(e);
        #1;
        checkOutput();
        @(posedge clk);
        modelEdge(aT, t, w, aR, rv, r);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mregs[i] = 16'h0000;
            mcnt[i]  = 0;
        end
        movf      = 1'b0;
        bus.addr1 = 3'd0;
        bus.addr2 = 3'd0;
        bus.addrT = 3'd0;
        bus.trgt  = 16'h0000;
        bus.wen   = 1'b0;
        bus.addrR = 3'd0;
        bus.resv  = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state on every address of both ports
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("reset_a%0d", i), 3'(i), 3'(7 - i),
                          3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        end

        // Write and read-back, with forwarding in the write cycle
        applyStimulus("wr_r1_bypass", 3'd1, 3'd2, 3'd1, 16'h1234, 1'b1, 3'd0, 1'b0, 1'b0);
        applyStimulus("rd_r1",        3'd1, 3'd1, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);

        // Register 0 ignores writes and reservations
        applyStimulus("wr_r0",        3'd0, 3'd0, 3'd0, 16'h2356, 1'b1, 3'd0, 1'b1, 1'b0);
        applyStimulus("rd_r0",        3'd0, 3'd1, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);

        // Scoreboard on r3
        applyStimulus("resv_r3_a",    3'd3, 3'd0, 3'd0, 16'h0,    1'b0, 3'd3, 1'b1, 1'b0);
        applyStimulus("resv_r3_b",    3'd3, 3'd0, 3'd0, 16'h0,    1'b0, 3'd3, 1'b1, 1'b0);
        applyStimulus("busy_r3_2",    3'd3, 3'd3, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus("wr_r3_a",      3'd3, 3'd0, 3'd3, 16'h3333, 1'b1, 3'd0, 1'b0, 1'b0);
        applyStimulus("busy_r3_1",    3'd3, 3'd0, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus("resv_wr_r3",   3'd3, 3'd0, 3'd3, 16'h4444, 1'b1, 3'd3, 1'b1, 1'b0);
        applyStimulus("busy_r3_kept", 3'd3, 3'd3, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus("wr_r3_b",      3'd3, 3'd0, 3'd3, 16'h5555, 1'b1, 3'd0, 1'b0, 1'b0);
        applyStimulus("busy_r3_0",    3'd3, 3'd3, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);

        // Saturation and the one-cycle ovf pulse on r5
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("resv_r5_%0d", i), 3'd0, 3'd5,
                          3'd0, 16'h0, 1'b0, 3'd5, 1'b1, 1'b0);
        end
        applyStimulus("ovf_pulse",    3'd5, 3'd5, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus("ovf_gone",     3'd5, 3'd5, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("wr_r5_%0d", i), 3'd0, 3'd5,
                          3'd5, 16'(16'hA000 + i), 1'b1, 3'd0, 1'b0, 1'b0);
        end
        applyStimulus("r5_idle",      3'd5, 3'd5, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);

        // Independent write and reserve to different registers
        applyStimulus("wr_r6_resv_r4", 3'd4, 3'd6, 3'd6, 16'h6666, 1'b1, 3'd4, 1'b1, 1'b0);
        applyStimulus("chk_r4_r6",     3'd4, 3'd6, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);

        // Reset in the middle of outstanding work on r2
        applyStimulus("wr_r2_beef",   3'd2, 3'd0, 3'd2, 16'hBEEF, 1'b1, 3'd0, 1'b0, 1'b0);
        applyStimulus("resv_r2_a",    3'd2, 3'd0, 3'd0, 16'h0,    1'b0, 3'd2, 1'b1, 1'b0);
        applyStimulus("resv_r2_b",    3'd2, 3'd0, 3'd0, 16'h0,    1'b0, 3'd2, 1'b1, 1'b0);
        applyStimulus("r2_pending",   3'd2, 3'd2, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus("rst_with_wr",  3'd2, 3'd4, 3'd2, 16'h1111, 1'b1, 3'd4, 1'b1, 1'b1);
        applyStimulus("after_rst_a",  3'd2, 3'd4, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus("after_rst_b",  3'd1, 3'd6, 3'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0);

        assertions++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule : tb_risc16_regfile_sb

// File: doc/risc16_regfile_sb.md
RISC16_REGFILE_SB -- requirements
Module: risc16_regfile_sb

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 16, data word width.
REQ-002 The block SHALL have parameter REG_ADDR_LEN, default 3, register address width.
REQ-003 The block SHALL have parameter REG_NUM, default 8, register count (at most 2**REG_ADDR_LEN).
REQ-004 The block SHALL have parameter PEND_W, default 2, width of the per-register pending-write counter.
REQ-005 The block SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-007 The block SHALL have ports addr1 in REG_ADDR_LEN, read port 1 address; src1 out WORD_LENGTH, read port 1 data; busy1 out 1, port 1 register has an outstanding write.
REQ-008 The block SHALL have ports addr2 in REG_ADDR_LEN, read port 2 address; src2 out WORD_LENGTH, read port 2 data; busy2 out 1, port 2 register has an outstanding write.
REQ-009 The block SHALL have ports addrT in REG_ADDR_LEN, write address; trgt in WORD_LENGTH, write data; wen in 1, write enable.
REQ-010 The block SHALL have ports addrR in REG_ADDR_LEN, reservation address; resv in 1, reserve request (issue of an instruction that will write addrR).
REQ-011 The block SHALL have port ovf out 1, registered; pulses for one cycle when a reservation is dropped on a saturated counter.

Function
REQ-012 Reads SHALL be combinational: src1/src2 present the stored word at addr1/addr2 in the same cycle.
REQ-013 Register 0 SHALL read 0; writes to it SHALL be ignored; reservations of it SHALL be ignored; busy for it SHALL be 0.
REQ-014 Addresses >= REG_NUM SHALL read 0 and SHALL be ignored for write and reserve.
REQ-015 On a rising clk edge with wen=1 and valid nonzero addrT, reg[addrT] SHALL take trgt.
REQ-016 With BYPASS=1, wen=1, addrT==addrN, addrN nonzero and valid, srcN SHALL equal trgt in the same cycle; with BYPASS=0, srcN SHALL show the old value until after the edge.
REQ-017 Each nonzero register SHALL own a PEND_W-bit counter cnt.
REQ-018 The counter SHALL update per edge: reserve only -> cnt+1; write only -> cnt-1; reserve and write to the same register -> unchanged.
REQ-019 A write with cnt=0 SHALL update data and leave cnt at 0 (no underflow).
REQ-020 A reserve with cnt at the maximum (2**PEND_W-1) and no same-register write SHALL leave cnt unchanged and set ovf=1 for the next cycle only.
REQ-021 busyN SHALL equal cnt[addrN] > h, where h=1 when BYPASS=1, wen=1 and addrT==addrN, else h=0.
REQ-022 Write and reserve to different registers in the same cycle SHALL both take effect independently.

Reset
REQ-023 On an edge with rst=1, all registers SHALL clear to 0, all counters to 0 and ovf to 0.
REQ-024 rst SHALL take priority over wen and resv in the same cycle; both SHALL be discarded.
REQ-025 After reset, src1, src2, busy1 and busy2 SHALL read 0 for every address, unless bypass applies.

Structure
REQ-026 Default parameter values and the zero-register index SHALL live in the shared defines.v.
REQ-027 The pending counter SHALL be a sub-module risc16_pend_counter (inc, dec, clr, cnt, sat), instantiated once per nonzero register by generate.
REQ-028 The implementation SHALL contain no latches; the storage array SHALL be reg-based and inferable as flops.

Verification
REQ-029 The bench SHALL cover reset: rst=1 for one edge -> src1=src2=0 and busy1=busy2=0 for addresses 0..7.
REQ-030 The bench SHALL cover write and read-back: addrT=1, trgt=16'h1234, wen=1 for one edge, then addr1=1 -> src1=16'h1234; with addr1=1 during the write cycle, src1=16'h1234 already in that cycle (BYPASS=1).
REQ-031 The bench SHALL cover register 0: addrT=0, trgt=16'h2356, wen=1 -> src1 at addr1=0 stays 0.
REQ-032 The bench SHALL cover the scoreboard: reserve r3 twice -> busy1 at addr1=3 is 1; one write to r3 -> busy1 still 1; second write -> busy1 0; a simultaneous reserve and write to r3 leaves cnt unchanged.
REQ-033 The bench SHALL cover saturation: four reserves to r5 with PEND_W=2 -> cnt=3 and ovf=1 for exactly one cycle after the fourth; then three writes -> busy 0.
REQ-034 The bench SHALL cover reset mid-operation: r2 holds 16'hBEEF with cnt=2; assert rst together with wen to r2 -> src=0, busy=0 and the write is lost.
